// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants, state encoding and channel-slice helper for
// the TDM channel multiplexer.
//   MODE_MANUAL / MODE_SCAN : values of the mode input
//   state_t                 : controller states IDLE / MANUAL / SCAN
//   ch_lsb()                : bit offset of channel ch in a packed bus
package tdm_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Channel ch of a packed bus occupies [ch*dw +: dw].
  function automatic int ch_lsb(input int ch, input int dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// rr_next_sel: combinational round-robin search over an enable mask.
//   mask    : enabled channels
//   cur     : search origin
//   restart : force nxt to the lowest enabled index
//   nxt     : next enabled index above cur, wrapping to the lowest enabled
//   lowest  : lowest enabled index (0 when none)
//   any_en  : at least one channel enabled
module rr_next_sel #(
  parameter int N_CH = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [SELW-1:0] cur,
  input  logic            restart,
  output logic [SELW-1:0] nxt,
  output logic [SELW-1:0] lowest,
  output logic            any_en
);

  logic [SELW-1:0] above;
  logic            found;

  always_comb begin
    any_en = |mask;
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (mask[i]) lowest = SELW'(i);

    above = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (!found && mask[i] && (i > int'(cur))) begin
        above = SELW'(i);
        found = 1'b1;
      end

    // Nothing above cur: the wrap segment 0..cur starts at the lowest index,
    // which may be cur itself (single enabled channel).
    nxt = (restart || !found) ? lowest : above;
  end

endmodule

// File: rtl/tdm_channel_mux.sv
// tdm_channel_mux: registered N-channel mux with manual select and
// automatic round-robin scan over enabled channels.
//   clk, reset   : clock, async active-high reset
//   en           : sample/advance enable
//   mode         : 0 manual (sel), 1 scan
//   sel          : manual channel select
//   ch_mask      : per-channel enable
//   din          : packed channel data, channel i at [i*DW +: DW]
//   dout         : registered selected data
//   dout_ch      : index of the channel on dout
//   dout_valid   : dout holds a legal enabled channel
//   frame_start  : dout carries the first channel of a scan frame
module tdm_channel_mux
  import tdm_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DW   = 1,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH*DW-1:0] din,
  output logic [DW-1:0]      dout,
  output logic [SELW-1:0]    dout_ch,
  output logic               dout_valid,
  output logic               frame_start
);

  state_t          state;
  logic [SELW-1:0] ptr;

  logic            restart;
  logic [SELW-1:0] cur_nxt, cur_lowest, cand, adv, adv_lowest;
  logic            cur_any, adv_any;
  logic            man_ok;
  logic            unused_adv;

  // Entering SCAN from any other state restarts the frame.
  assign restart = (state != SCAN);

  rr_next_sel #(.N_CH(N_CH), .SELW(SELW)) u_cur (
    .mask    (ch_mask),
    .cur     (ptr),
    .restart (restart),
    .nxt     (cur_nxt),
    .lowest  (cur_lowest),
    .any_en  (cur_any)
  );

  // Emit ptr if it is still enabled; if the mask just dropped it, emit the
  // next enabled channel instead so no cycle is wasted.
  assign cand = (!restart && ch_mask[ptr]) ? ptr : cur_nxt;

  rr_next_sel #(.N_CH(N_CH), .SELW(SELW)) u_adv (
    .mask    (ch_mask),
    .cur     (cand),
    .restart (1'b0),
    .nxt     (adv),
    .lowest  (adv_lowest),
    .any_en  (adv_any)
  );

  assign unused_adv = ^{adv_lowest, adv_any};

  assign man_ok = (int'(sel) < N_CH) && ch_mask[sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      dout        <= '0;
      dout_ch     <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (mode == MODE_MANUAL) begin
      state       <= MANUAL;
      dout_ch     <= sel;
      dout_valid  <= man_ok;
      dout        <= man_ok ? din[ch_lsb(int'(sel), DW) +: DW] : '0;
      frame_start <= 1'b0;
    end else begin
      state <= SCAN;
      if (cur_any) begin
        dout        <= din[ch_lsb(int'(cand), DW) +: DW];
        dout_ch     <= cand;
        dout_valid  <= 1'b1;
        frame_start <= (cand == cur_lowest);
        ptr         <= adv;
      end else begin
        // Empty mask: nothing to emit, pointer and index hold.
        dout        <= '0;
        dout_valid  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tdm_channel_mux.md
Name: tdm_channel_mux

Overview:
Parametrised, registered N-channel multiplexer that supersedes the fixed 8:1 gate-level mux.
- Adds multi-bit channel width and a per-channel enable mask.
- Two modes: manual select, or automatic time-division scan across enabled channels.
- Emits the selected channel index, a valid flag and a frame-start marker so downstream logic (serial/BCD display drivers, FSM consumers) can track which source is on the output.

Parameters:
N_CH, 8, number of input channels (2..64)
DW, 1, data width per channel in bits
SELW, $clog2(N_CH), width of select/index buses (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  advance/sample enable; outputs update only when high
mode  input  1  0 = MANUAL (use sel), 1 = SCAN (auto round-robin)
sel  input  SELW  channel select in MANUAL mode
ch_mask  input  N_CH  bit i = 1 means channel i is enabled
din  input  N_CH*DW  packed channel data; channel i at bits [i*DW +: DW]
dout  output  DW  registered selected data
dout_ch  output  SELW  index of the channel currently on dout
dout_valid  output  1  dout/dout_ch hold a legal enabled channel this cycle
frame_start  output  1  one-cycle pulse: dout carries first channel of a scan frame

Behaviour:
- Reset (async, active-high): dout=0, dout_ch=0, dout_valid=0, frame_start=0, scan pointer=0, state=IDLE. Release takes effect on the next clk edge.
- Latency: one clk from an en=1 sample of din/sel/mask to dout. All outputs are registered; there is no combinational input-to-output path.
- en=0: dout and dout_ch hold; dout_valid=0; frame_start=0; scan pointer holds.
- States:
  - IDLE: entered after reset. On en=1, go to MANUAL (mode=0) or SCAN (mode=1), performing that state's sample in the same cycle.
  - MANUAL: each en=1 cycle, latch ch=sel.
    - If sel<N_CH and ch_mask[sel]=1: dout=din[sel], dout_ch=sel, dout_valid=1.
    - Else: dout=0, dout_ch=sel, dout_valid=0.
    - frame_start is always 0.
  - SCAN: each en=1 cycle, emit pointer channel p, then advance p to the next enabled index above p, wrapping to the lowest enabled index.
    - frame_start=1 when the emitted p is the lowest enabled index.
- Mode switch (mode changes while en=1): takes effect in the same cycle.
  - MANUAL->SCAN: pointer restarts at the lowest enabled index, so the first SCAN output has frame_start=1.
  - SCAN->MANUAL: pointer is discarded.
- Mask changes mid-scan: the next pointer is computed with the new mask in the same cycle.
  - If the current p became disabled, emit the next enabled index above p (wrapping) instead, with dout_valid=1.
- All-zero mask in SCAN: dout_valid=0, dout=0, frame_start=0, pointer holds.
- Single enabled channel in SCAN: that channel is emitted every en cycle with frame_start=1 every cycle.
- Wrap-around: search order is p+1 .. N_CH-1, then 0 .. p. Indices >= N_CH are never produced.

Decomposition:
- Shared package tdm_pkg:
  - mode constants MODE_MANUAL=0, MODE_SCAN=1.
  - state enum {IDLE, MANUAL, SCAN}.
  - function for the packed-channel slice.
- Sub-module rr_next_sel (combinational):
  - inputs: mask, cur index, restart flag.
  - outputs: next enabled index with wrap, lowest enabled index, any_enabled.
  - Shared by the pointer-advance and mask-change logic.

Test Plan:
1. Reset mid-scan: assert reset asynchronously between edges -> all outputs 0 immediately; after release with en=1, mode=1, mask=8'hFF, the first output is ch0 with frame_start=1.
2. SCAN, N_CH=8, DW=4, mask=8'b1010_0101, din ch i = i+1, en=1 -> dout_ch sequence 0,2,5,7,0,...; dout 1,3,6,8,1; frame_start on each ch0.
3. MANUAL, sel=3, mask bit3=1, din ch3=4'hA -> next cycle dout=A, dout_valid=1. Then clear mask bit3 -> dout=0, dout_valid=0, dout_ch=3.
4. en toggling in SCAN (en=1,0,0,1) -> outputs hold over the en=0 cycles with dout_valid=0; the scan resumes at the next channel with none skipped.
5. Mask edge cases: mask=0 in SCAN -> dout_valid stays 0. mask=8'b0001_0000 -> ch4 every cycle with frame_start=1. Clear the current channel's mask bit mid-scan -> the next enabled channel is emitted.
6. Mode switch SCAN->MANUAL->SCAN with sel=6 -> one cycle ch6, then SCAN restarts at the lowest enabled index with frame_start=1. Also run N_CH=5: sel=7 in MANUAL -> dout_valid=0.
